// File: rtl/byte_ram_sync.sv
// byte_ram_sync: synchronous byte-addressed data RAM for the memory stage.
// Serves big-endian byte/halfword/word loads and stores over a valid/ready
// request channel. A request is accepted in IDLE, waits WAIT_STATES cycles,
// and is answered by a one-cycle rsp_valid pulse. The memory access itself
// happens on the clock edge entering RESP.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_we           0 read, 1 write
//   req_size         00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed       sign-extend byte/halfword loads
//   req_addr         byte address (ADDR_W bits)
//   req_wdata        right-justified store data
//   rsp_valid        one-cycle response pulse
//   rsp_rdata        load data (0 for writes and errors), held until next response
//   rsp_err          access rejected, held until next response
//
// Build option: define RAM_MISALIGN_TRAP_EN to report misaligned halfword/word
// accesses as errors; otherwise the low address bits are forced to zero.
module byte_ram_sync #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       acc_fire;

    logic [7:0] mem [DEPTH];

    // Request fields captured at accept
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    // Fields used by the access: with zero wait states the access happens on
    // the accept edge itself, before the latches hold the request.
    logic              acc_we;
    logic [1:0]        acc_size;
    logic              acc_signed;
    logic [ADDR_W-1:0] acc_addr_raw;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic              acc_err;
    logic [7:0]        rb0, rb1, rb2, rb3;
    logic              fill;
    logic [31:0]       rdata_fmt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        acc_fire   = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                        acc_fire   = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = S_RESP;
                    acc_fire   = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    always_comb begin
        if (state == S_IDLE) begin
            acc_we       = req_we;
            acc_size     = req_size;
            acc_signed   = req_signed;
            acc_addr_raw = req_addr;
            acc_wdata    = req_wdata;
        end else begin
            acc_we       = lat_we;
            acc_size     = lat_size;
            acc_signed   = lat_signed;
            acc_addr_raw = lat_addr;
            acc_wdata    = lat_wdata;
        end
    end

`ifdef RAM_MISALIGN_TRAP_EN
    always_comb begin
        a0      = acc_addr_raw;
        acc_err = (acc_size == 2'b11)
               || (acc_size == 2'b01 && acc_addr_raw[0])
               || (acc_size == 2'b10 && acc_addr_raw[1:0] != 2'b00);
    end
`else
    always_comb begin
        a0      = acc_addr_raw;
        acc_err = (acc_size == 2'b11);
        if (acc_size == 2'b01) begin
            a0[0] = 1'b0;
        end else if (acc_size == 2'b10) begin
            a0[1:0] = 2'b00;
        end
    end
`endif

    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);

    assign rb0 = mem[a0];
    assign rb1 = mem[a1];
    assign rb2 = mem[a2];
    assign rb3 = mem[a3];

    always_comb begin
        fill      = 1'b0;
        rdata_fmt = '0;
        unique case (acc_size)
            2'b00: begin
                fill      = acc_signed & rb0[7];
                rdata_fmt = {{24{fill}}, rb0};
            end
            2'b01: begin
                fill      = acc_signed & rb0[7];
                rdata_fmt = {{16{fill}}, rb0, rb1};
            end
            2'b10:   rdata_fmt = {rb0, rb1, rb2, rb3};
            default: rdata_fmt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (acc_fire) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || acc_we) ? '0 : rdata_fmt;
        end
    end

    // Reset on the commit edge must still suppress the write.
    always_ff @(posedge clk) begin
        if (!reset && acc_fire && acc_we && !acc_err) begin
            unique case (acc_size)
                2'b00: mem[a0] <= acc_wdata[7:0];
                2'b01: begin
                    mem[a0] <= acc_wdata[15:8];
                    mem[a1] <= acc_wdata[7:0];
                end
                2'b10: begin
                    mem[a0] <= acc_wdata[31:24];
                    mem[a1] <= acc_wdata[23:16];
                    mem[a2] <= acc_wdata[15:8];
                    mem[a3] <= acc_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_ram_sync.sv
// Self-checking bench for byte_ram_sync. Three instances are used:
// index 0 with WAIT_STATES=1, index 1 with WAIT_STATES=3, index 2 with 0.
module tb_byte_ram_sync;

`ifdef RAM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [1:0]  req_size   [3];
    logic        req_signed [3];
    logic [7:0]  req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_err    [3];

    int checks = 0;
    int passed = 0;

    logic [7:0] model_mem [256];

    always #5 clk = ~clk;

    byte_ram_sync #(.ADDR_W(8), .WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    byte_ram_sync #(.ADDR_W(8), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    byte_ram_sync #(.ADDR_W(8), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_size(req_size[2]), .req_signed(req_signed[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input int k, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [7:0] addr, input logic [31:0] wd);
        req_we[k]     = we;
        req_size[k]   = size;
        req_signed[k] = sgn;
        req_addr[k]   = addr;
        req_wdata[k]  = wd;
    endtask

    // One complete access; lat counts cycles from accept to rsp_valid, -1 on timeout.
    task automatic access(input int k, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        drive(k, we, size, sgn, addr, wd);
        req_valid[k] = 1'b1;
        @(negedge clk);
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[k]) lat = -1;
        rd  = rsp_rdata[k];
        err = rsp_err[k];
    endtask

    // Reference: byte-array memory, big-endian assembly by arithmetic.
    task automatic model_op(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [7:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
        int n;
        int unsigned a;
        longint v;
        rd  = '0;
        err = 1'b0;
        if (size == 2'b11) begin
            err = 1'b1;
        end else begin
            n = 1 << size;
            a = addr;
            if (TRAP && (a % n) != 0) begin
                err = 1'b1;
            end else begin
                a = a - (a % n);
                if (we) begin
                    for (int i = 0; i < n; i++)
                        model_mem[(a + i) % 256] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
                end else begin
                    v = 0;
                    for (int i = 0; i < n; i++)
                        v = v * 256 + longint'(model_mem[(a + i) % 256]);
                    if (sgn && n < 4 && v >= (64'sd1 << (8 * n - 1)))
                        v = v - (64'sd1 << (8 * n));
                    rd = 32'(v);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [15];
        logic [31:0] rd, mrd, rd3;
        logic        err, merr, seen;
        int          lat, pulses;

        for (int k = 0; k < 3; k++) begin
            reset[k]     = 1'b1;
            req_valid[k] = 1'b0;
            drive(k, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
        end

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 8'h10, 32'h0,        32'h000000DE, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 8'h10, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 8'h12, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 8'h20, 32'h12348001, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 8'h20, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 8'h20, 32'h0,        32'h00008001, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 8'h21, 32'h0,        32'h00000001, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 8'h13, 32'h11223344, 32'h0,        TRAP};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,
                     TRAP ? 32'hDEADBEEF : 32'h11223344, 1'b0};
        vecs[11] = '{1'b0, 2'b11, 1'b1, 8'h00, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 8'h10, 32'h55555555, 32'h0,        1'b1};
        vecs[13] = vecs[10];
        vecs[14] = '{1'b0, 2'b01, 1'b0, 8'h11, 32'h0,
                     TRAP ? 32'h0 : 32'h00001122, TRAP};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_state%0d", k),
                  {29'b0, req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]},
                  {29'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;

        // Directed table on the WAIT_STATES=1 instance
        for (int i = 0; i < 15; i++) begin
            access(0, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rd, err, lat);
            check($sformatf("vec%0d", i), {lat[15:0], 15'b0, err, rd},
                  {16'd2, 15'b0, vecs[i].exp_err, vecs[i].exp_rd});
        end

        // Abort by reset on the WAIT_STATES=3 instance: mid-wait, then on the commit edge
        access(1, 1'b1, 2'b10, 1'b0, 8'h40, 32'h01020304, rd, err, lat);
        check("ws3_prewrite", {lat[15:0], 15'b0, err, rd}, {16'd4, 15'b0, 1'b0, 32'h0});
        for (int when = 2; when <= 3; when++) begin
            @(negedge clk);
            drive(1, 1'b1, 2'b10, 1'b0, 8'h40, 32'hCAFEF00D);
            req_valid[1] = 1'b1;
            @(negedge clk);
            req_valid[1] = 1'b0;
            seen = 1'b0;
            for (int c = 1; c < when; c++) begin
                if (rsp_valid[1]) seen = 1'b1;
                @(negedge clk);
            end
            reset[1] = 1'b1;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                if (rsp_valid[1]) seen = 1'b1;
            end
            reset[1] = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (rsp_valid[1]) seen = 1'b1;
            end
            check($sformatf("abort%0d_no_rsp", when), {63'b0, seen}, 64'd0);
            check($sformatf("abort%0d_ready", when), {63'b0, req_ready[1]}, 64'd1);
            access(1, 1'b0, 2'b10, 1'b0, 8'h40, 32'h0, rd, err, lat);
            check($sformatf("abort%0d_mem", when), {lat[15:0], 15'b0, err, rd},
                  {16'd4, 15'b0, 1'b0, 32'h01020304});
        end

        // Back-to-back on the WAIT_STATES=0 instance with req_valid held high
        @(negedge clk);
        drive(2, 1'b1, 2'b10, 1'b0, 8'h80, 32'hA0A0A0A0);
        req_valid[2] = 1'b1;
        pulses = 0;
        rd3 = '0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("b2b_ready_c%0d", c), {63'b0, req_ready[2]},
                  {63'b0, !((c % 2 == 1) && c < 6)});
            check($sformatf("b2b_valid_c%0d", c), {63'b0, rsp_valid[2]},
                  {63'b0, (c % 2 == 1) && c < 6});
            if (rsp_valid[2]) begin
                pulses++;
                if (pulses == 3) rd3 = rsp_rdata[2];
            end
            if (c == 1) drive(2, 1'b1, 2'b00, 1'b0, 8'h81, 32'h0000005B);
            if (c == 3) drive(2, 1'b0, 2'b10, 1'b0, 8'h80, 32'h0);
            if (c == 5) req_valid[2] = 1'b0;
            @(negedge clk);
        end
        check("b2b_pulses", 64'(pulses), 64'd3);
        check("b2b_rdata", {32'b0, rd3}, {32'b0, 32'hA05BA0A0});

        // Randomized run against the model on the WAIT_STATES=1 instance
        for (int i = 0; i < 64; i++) begin
            logic [31:0] wd;
            wd = $urandom;
            model_op(1'b1, 2'b10, 1'b0, 8'(i * 4), wd, mrd, merr);
            access(0, 1'b1, 2'b10, 1'b0, 8'(i * 4), wd, rd, err, lat);
            check("fill", {lat[15:0], 15'b0, err, rd}, {16'd2, 15'b0, merr, mrd});
        end
        for (int i = 0; i < 300; i++) begin
            logic        we, sgn;
            logic [1:0]  size;
            logic [7:0]  addr;
            logic [31:0] wd;
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 8'($urandom_range(0, 255));
            wd   = $urandom;
            model_op(we, size, sgn, addr, wd, mrd, merr);
            access(0, we, size, sgn, addr, wd, rd, err, lat);
            check($sformatf("rand%0d", i), {lat[15:0], 15'b0, err, rd}, {16'd2, 15'b0, merr, mrd});
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/byte_ram_sync.md
# byte_ram_sync

Parametrised, synchronous successor to the combinational 256-byte data RAM. It serves big-endian byte, halfword and word loads and stores for the datapath's memory stage. Access uses a valid/ready request channel and a one-cycle response pulse after a programmable number of wait states. It adds sign extension, alignment checking and an error response.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; depth = 2^ADDR_W bytes
- WAIT_STATES, 1, extra cycles between request accept and response (0..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  0 read, 1 write
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  reads only: sign-extend byte/halfword
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load data; 0 for writes and errors
- rsp_err  out  1  access rejected, valid with rsp_valid

One clock; reset is synchronous and active-high.

## Operation
- Storage is 2^ADDR_W × 8-bit. Contents are not cleared by reset.
- All multi-byte accesses are big-endian: the byte at addr is most significant.
- FSM states:
  - IDLE: req_ready=1. When req_valid is high, latch all req_* fields and go to WAIT; if WAIT_STATES=0, go directly to RESP.
  - WAIT: a down-counter is loaded with WAIT_STATES-1. Stay while the count is nonzero, then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- The memory access executes on the clock edge entering RESP.
  - A write commits on that edge.
  - For a read, rsp_rdata is registered on that edge.
- Read formatting:
  - byte: {24 fill, M[a]}
  - halfword: {16 fill, M[a], M[a+1]}
  - word: {M[a], M[a+1], M[a+2], M[a+3]}
  - fill = replicated data MSB when req_signed=1, otherwise 0.
- Write: byte uses wdata[7:0]; halfword uses wdata[15:0] (M[a]=wdata[15:8]); word uses the full 32 bits (M[a]=wdata[31:24]).
- Error: req_size=11 always gives rsp_err=1, rsp_rdata=0 and no memory write. Alignment errors depend on the configuration below.
- req_* inputs are ignored outside IDLE. No request is queued.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, counter=0.
- Accept-to-response latency is WAIT_STATES+1 cycles: rsp_valid is high in cycle accept+WAIT_STATES+1.
- Throughput: one access per WAIT_STATES+2 cycles. req_ready is low from the cycle after accept through the RESP cycle.
- rsp_rdata and rsp_err hold their values until the next response. They are meaningful only while rsp_valid=1.
- Reset asserted mid-access aborts the access.
  - A write not yet committed (reset on or before the commit edge) must not modify memory.
  - No rsp_valid is produced.
- Read-after-write to the same address: the read accepted in the IDLE cycle after the write's RESP returns the new data.
- Address arithmetic (a+1..a+3) is ADDR_W-bit and wraps modulo depth. Wrap occurs only when alignment trapping is compiled out and aligning is bypassed; see below.

## Configuration
- Macro: RAM_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]≠0, or a word with addr[1:0]≠0, produces rsp_err=1, rsp_rdata=0 and no write.
- Undefined: the low address bits are forced to zero for aligned sizes (halfword addr[0]=0, word addr[1:0]=0). The access then proceeds normally with rsp_err=0. Only size=11 errors.

## Test plan
- Reset, then with WAIT_STATES=1: write word 0xDEADBEEF @0x10, then read word @0x10. Required: rsp_rdata=0xDEADBEEF; byte read @0x10 returns 0x000000DE; rsp_valid appears exactly 2 cycles after each accept.
- Signed/unsigned loads after storing halfword 0x8001 @0x20:
  - signed halfword read → 0xFFFF8001
  - unsigned halfword read → 0x00008001
  - signed byte read @0x21 → 0x00000001
- Misalignment: word write 0x11223344 @0x13.
  - With RAM_MISALIGN_TRAP_EN: rsp_err=1 and bytes 0x10..0x13 unchanged.
  - Without it: rsp_err=0 and bytes 0x10..0x13 = 11 22 33 44.
- Illegal size: req_size=11 read @0x00 → rsp_err=1, rsp_rdata=0, memory unchanged.
- Reset mid-write: WAIT_STATES=3, word write 0xCAFEF00D @0x40, reset asserted 2 cycles after accept. Required: no rsp_valid, req_ready=1 after reset, word read @0x40 returns the old value.
- Back-to-back requests: hold req_valid high for 3 requests with WAIT_STATES=0. Required: requests are accepted in cycles 0, 2 and 4; req_ready is low in cycles 1, 3 and 5; exactly 3 rsp_valid pulses.
